// File: rtl/xor_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xor_cipher_ctrl
// Brief    : Key/packet sequencer in front of an 8-bit XOR cipher core.
//            Optional rolling key enabled by macro XOR_KEY_ROLL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xor_cipher_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int MAX_PKT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [DATA_W-1:0] key_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              core_load_key,
  output logic [DATA_W-1:0] core_new_key,
  output logic [DATA_W-1:0] core_plaintext,
  input  logic [DATA_W-1:0] core_cipher,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              overrun
);

  typedef enum logic [1:0] {
    ST_NOKEY   = 2'd0,
    ST_LOADKEY = 2'd1,
    ST_READY   = 2'd2,
    ST_STREAM  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] base_key_q, base_key_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              overrun_q, overrun_d;

  logic out_free;
  logic key_hs;
  logic accept;
  logic eff_last;

  assign core_plaintext = s_data;
  assign out_free       = !m_valid_q || m_ready;
  assign eff_last       = s_last || (byte_cnt_q == LAST_IDX);

  // Handshake readiness depends only on state and inputs, never on accept.
  always_comb begin
    key_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_NOKEY: begin
        key_ready = 1'b1;
      end
      ST_READY: begin
        key_ready = 1'b1;
        s_ready   = out_free && !key_valid;
      end
      ST_STREAM: begin
        busy    = 1'b1;
        s_ready = out_free;
      end
      default: begin
        key_ready = 1'b0;
      end
    endcase
  end

  assign key_hs = key_valid && key_ready;
  assign accept = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NOKEY: begin
        if (key_hs) state_d = ST_LOADKEY;
      end
      ST_LOADKEY: begin
        state_d = ST_READY;
      end
      ST_READY: begin
        if (key_hs)                   state_d = ST_LOADKEY;
        else if (accept && !eff_last) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && eff_last) state_d = ST_READY;
      end
      default: begin
        state_d = ST_NOKEY;
      end
    endcase
  end

  always_comb begin
    base_key_d = key_hs ? key_in : base_key_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    byte_cnt_d = byte_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    overrun_d  = overrun_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = core_cipher;
      m_last_d  = eff_last;
      if (eff_last) begin
        byte_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 1'b1;
        if (!s_last) overrun_d = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

`ifdef XOR_KEY_ROLL_EN
  // Mirror of the key held inside the core, so the next roll step is known.
  logic [DATA_W-1:0] cur_key_q, cur_key_d;

  always_comb begin
    core_load_key = (state_q == ST_LOADKEY) || accept;
    if (accept && !eff_last) begin
      core_new_key = {cur_key_q[DATA_W-2:0], cur_key_q[DATA_W-1]};
    end else begin
      core_new_key = base_key_q;
    end
    cur_key_d = core_load_key ? core_new_key : cur_key_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_key_q <= '0;
    end else begin
      cur_key_q <= cur_key_d;
    end
  end
`else
  assign core_load_key = (state_q == ST_LOADKEY);
  assign core_new_key  = base_key_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NOKEY;
      base_key_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      byte_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_key_q <= base_key_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign byte_cnt = byte_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_cipher_ctrl
// Brief    : Self-checking bench for xor_cipher_ctrl with an attached core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_cipher_ctrl;
  localparam int MAXP = 4;
`ifdef XOR_KEY_ROLL_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0, key_ready;
  logic [7:0] key_in = 8'h00;
  logic       s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_valid, m_last, m_ready = 1'b0;
  logic [7:0] m_data;
  logic       core_load_key;
  logic [7:0] core_new_key, core_plaintext, core_cipher;
  logic       busy, overrun;
  logic [7:0] byte_cnt, pkt_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xor_cipher_ctrl #(.DATA_W(8), .CNT_W(8), .MAX_PKT(MAXP)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_load_key(core_load_key), .core_new_key(core_new_key),
    .core_plaintext(core_plaintext), .core_cipher(core_cipher),
    .busy(busy), .byte_cnt(byte_cnt), .pkt_cnt(pkt_cnt), .overrun(overrun)
  );

  // Cipher core: key register plus combinational XOR.
  logic [7:0] core_key = 8'h00;
  always @(posedge clk) if (core_load_key) core_key <= core_new_key;
  assign core_cipher = core_plaintext ^ core_key;

  // Reference model state
  bit       md_have_key, md_loading, md_in_pkt, md_ovr, md_ov, md_ol;
  bit [7:0] md_base, md_cur, md_od, md_pcnt;
  int       md_bcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_have_key = 0; md_loading = 0; md_in_pkt = 0; md_ovr = 0;
    md_ov = 0; md_ol = 0; md_od = 8'h00; md_pcnt = 8'h00; md_bcnt = 0;
    md_base = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_valid = 0; key_in = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_core_load_key", 32'(core_load_key), 32'd0);
    chk("rst_core_new_key", 32'(core_new_key), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  // One clock of stimulus: check combinational outputs, clock, advance model, check registers.
  task automatic cycle(input logic kv, input logic [7:0] kin, input logic sv,
                       input logic [7:0] sd, input logic sl, input logic mr);
    bit e_kr, e_sr, acc, khs, elast;
    key_valid = kv; key_in = kin; s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
    #1;
    e_kr  = !md_loading && !md_in_pkt;
    e_sr  = md_have_key && !md_loading && (!md_ov || mr) && (md_in_pkt || !kv);
    khs   = kv && e_kr;
    acc   = sv && e_sr;
    elast = sl || (md_bcnt == MAXP - 1);
    chk("key_ready", 32'(key_ready), 32'(e_kr));
    chk("s_ready", 32'(s_ready), 32'(e_sr));
    chk("core_load_key", 32'(core_load_key), 32'(md_loading || (ROLL && acc)));
    chk("busy", 32'(busy), 32'(md_in_pkt));
    @(posedge clk);
    if (khs) begin
      md_base = kin; md_loading = 1;
    end else if (md_loading) begin
      md_loading = 0; md_have_key = 1; md_cur = md_base;
    end
    if (acc) begin
      md_od = sd ^ md_cur; md_ol = elast; md_ov = 1;
      if (elast) begin
        md_bcnt = 0; md_pcnt = md_pcnt + 8'd1; md_in_pkt = 0;
        if (!sl) md_ovr = 1;
        if (ROLL) md_cur = md_base;
      end else begin
        md_bcnt++; md_in_pkt = 1;
        if (ROLL) md_cur = {md_cur[6:0], md_cur[7]};
      end
    end else if (md_ov && mr) begin
      md_ov = 0;
    end
    #1;
    chk("m_valid", 32'(m_valid), 32'(md_ov));
    chk("m_data", 32'(m_data), 32'(md_od));
    chk("m_last", 32'(m_last), 32'(md_ol));
    chk("byte_cnt", 32'(byte_cnt), 32'(md_bcnt));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(md_pcnt));
    chk("overrun", 32'(overrun), 32'(md_ovr));
  endtask

  typedef struct {
    logic kv; logic [7:0] kin; logic sv; logic [7:0] sd; logic sl; logic mr;
    logic ev; logic [7:0] ed; logic el;
  } vec_t;

  initial begin
    vec_t tbl[7];
    tbl[0] = '{1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, (ROLL ? 8'hAA : 8'h55), 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1};

    model_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].kv, tbl[i].kin, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_m_data", i), 32'(m_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_m_last", i), 32'(m_last), 32'(tbl[i].el));
    end
    chk("tbl_pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("tbl_byte_cnt", 32'(byte_cnt), 32'd0);

    // Backpressure: output stalls, then the rest of the packet follows.
    cycle(0, 8'h00, 1, 8'h00, 0, 0);
    chk("bp_first", 32'(m_data), 32'hAA);
    cycle(0, 8'h00, 1, 8'hFF, 0, 0);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_hold", 32'(m_data), 32'hAA);
    cycle(0, 8'h00, 1, 8'hFF, 0, 1);
    chk("bp_second", 32'(m_data), ROLL ? 32'hAA : 32'h55);
    cycle(0, 8'h00, 1, 8'h55, 1, 1);
    chk("bp_third", 32'(m_data), 32'hFF);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);

    // Key offered mid-packet waits for the packet to finish.
    cycle(0, 8'h00, 1, 8'h11, 0, 1);
    cycle(1, 8'h0F, 1, 8'h22, 0, 1);
    chk("mid_key_ready", 32'(key_ready), 32'd0);
    cycle(1, 8'h0F, 1, 8'h33, 1, 1);
    cycle(1, 8'h0F, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 8'hF0, 1, 1);
    chk("newkey_data", 32'(m_data), 32'hFF);

    // Forced last after MAXP bytes, then reset mid-packet.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'h00, 1, 8'(i), 0, 1);
      if (i == 3) begin
        chk("force_m_last", 32'(m_last), 32'd1);
        chk("force_overrun", 32'(overrun), 32'd1);
      end
    end
    chk("force_next_cnt", 32'(byte_cnt), 32'd1);
    chk("force_next_last", 32'(m_last), 32'd0);
    do_reset();
    cycle(0, 8'h00, 1, 8'h12, 0, 1);
    chk("post_rst_s_ready", 32'(s_ready), 32'd0);
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);

`ifdef XOR_KEY_ROLL_EN
    cycle(1, 8'h81, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 8'h00, 0, 1);
    chk("roll_b0", 32'(m_data), 32'h81);
    cycle(0, 8'h00, 1, 8'h00, 0, 1);
    chk("roll_b1", 32'(m_data), 32'h03);
    cycle(0, 8'h00, 1, 8'h00, 1, 1);
    chk("roll_b2", 32'(m_data), 32'h06);
    cycle(0, 8'h00, 1, 8'h00, 1, 1);
    chk("roll_next_pkt", 32'(m_data), 32'h81);
`endif

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
              8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
